// File: rtl/pc_seq_unit.sv
// pc_seq_unit: program-counter sequencing stage of the multicycle MIPS datapath.
// This block owns the PC and ALUOut registers. It selects the next PC from the
// ALU result, ALUOut, a jump target or a jr target. It rejects misaligned write
// targets, sets a sticky misalign flag for them and pulses redirect for one
// cycle after each accepted control transfer.
//
// Optional feature: define PC_TRACE_EN to build a TRACE_DEPTH-entry circular
// buffer that records the targets of taken control transfers. When PC_TRACE_EN
// is not defined, the trace ports are still present but read as zero, and no
// trace storage is built.
//
// Write-request semantics: there is no handshake on this block. The control
// unit raises PCWr (unconditional) or PCWrcond (qualified by zero) for one
// cycle. The request is consumed at that same rising edge, so the block never
// back-pressures the control unit.
module pc_seq_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TRACE_DEPTH = 8,
  localparam int         CW          = $clog2(TRACE_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          PCWr,
  input  logic          PCWrcond,
  input  logic [1:0]    PCsrc,
  input  logic          zero,
  input  logic [31:0]   alu_result,
  input  logic [25:0]   jidx,
  input  logic [31:0]   jr_addr,
  output logic [31:0]   pc,
  output logic [31:0]   alu_out,
  output logic          redirect,
  output logic          misalign,
  input  logic [CW-1:0] trace_idx,
  output logic [31:0]   trace_data,
  output logic [CW-1:0] trace_count
);

  localparam logic [1:0] SRC_ALU    = 2'b00;
  localparam logic [1:0] SRC_ALUOUT = 2'b01;
  localparam logic [1:0] SRC_JUMP   = 2'b10;
  localparam logic [1:0] SRC_JR     = 2'b11;

  logic [31:0] pc_q;
  logic [31:0] alu_out_q;
  logic        redirect_q;
  logic        misalign_q;

  logic [31:0] next_pc;
  logic        wr_req;
  logic        aligned;
  logic        accept;
  logic        transfer;

  // The write request is granted when PCWr is high, or when PCWrcond is high
  // and zero is set. PCWr wins whenever it is high.
  assign wr_req = PCWr | (PCWrcond & zero);

  // Select the next PC. The jump target takes its top nibble from the PC that
  // fetch has already incremented.
  always_comb begin
    next_pc = alu_result;
    unique case (PCsrc)
      SRC_ALU:    next_pc = alu_result;
      SRC_ALUOUT: next_pc = alu_out_q;
      SRC_JUMP:   next_pc = {pc_q[31:28], jidx, 2'b00};
      SRC_JR:     next_pc = jr_addr;
      default:    next_pc = alu_result;
    endcase
  end

  assign aligned  = (next_pc[1:0] == 2'b00);
  assign accept   = wr_req & aligned;
  assign transfer = accept & (PCsrc != SRC_ALU);

  // Hold the PC and the ALUOut register. ALUOut loads on every edge, so a
  // branch target computed in ID is ready in BR. An accepted write updates the
  // PC; a misaligned one leaves the PC unchanged and sets the sticky flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      alu_out_q  <= 32'h0000_0000;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      alu_out_q  <= alu_result;
      redirect_q <= transfer;
      if (accept) begin
        pc_q <= next_pc;
      end
      if (wr_req && !aligned) begin
        misalign_q <= 1'b1;
      end
    end
  end

  assign pc       = pc_q;
  assign alu_out  = alu_out_q;
  assign redirect = redirect_q;
  assign misalign = misalign_q;

`ifdef PC_TRACE_EN
  localparam int AW = $clog2(TRACE_DEPTH);

  logic [31:0]   trace_mem [TRACE_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic [AW-1:0] rd_sel;

  // Advance the write pointer, and the saturating entry count, on each push.
  // Reset clears only this bookkeeping; the buffer contents are left as they are.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (transfer) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (count_q != CW'(TRACE_DEPTH)) begin
        count_q <= count_q + CW'(1);
      end
    end
  end

  // The storage has no reset. It is gated by rst so that a reset overrides a
  // push that would otherwise happen in the same cycle.
  always_ff @(posedge clk) begin
    if (transfer && !rst) begin
      trace_mem[wr_ptr] <= next_pc;
    end
  end

  // Read combinationally, newest first. Index 0 is the entry just below wr_ptr,
  // so a push at the same edge as a read returns the contents from before the edge.
  always_comb begin
    rd_sel     = wr_ptr - AW'(1) - trace_idx[AW-1:0];
    trace_data = 32'h0000_0000;
    if (trace_idx < count_q) begin
      trace_data = trace_mem[rd_sel];
    end
  end

  assign trace_count = count_q;
`else
  logic unused_trace_idx;

  assign unused_trace_idx = ^trace_idx;
  assign trace_data       = 32'h0000_0000;
  assign trace_count      = '0;
`endif

endmodule
